// File: rtl/alu_pkg.sv
// Shared ALU command encodings, scheduler state type and operand payload.
package alu_pkg;

  localparam int unsigned CMD_W = 4;
  localparam int unsigned OPD_W = 4;
  localparam int unsigned RES_W = 8;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_NAND   = 4'd5,
    ALU_NOR    = 4'd6,
    ALU_XNOR   = 4'd7,
    ALU_SHL    = 4'd8,
    ALU_SHR    = 4'd9,
    ALU_INC_A  = 4'd10,
    ALU_DEC_A  = 4'd11,
    ALU_PASS_A = 4'd12,
    ALU_PASS_B = 4'd13,
    ALU_NOT_A  = 4'd14,
    ALU_NOT_B  = 4'd15
  } alu_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [OPD_W-1:0] a;
    logic [OPD_W-1:0] b;
  } alu_op_t;

  // Increment with wrap at n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_grant #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_grant,
  output logic               o_any
);

  int w_idx;

  // Scan from farthest to nearest so the nearest requester at/after ptr wins.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = 0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % int'(NUM_REQ);
      if (i_req[ID_W'(w_idx)]) begin
        o_grant = ID_W'(w_idx);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational ALU among NUM_REQ requesters,
// one transaction per grant: IDLE (accept) -> EXEC (ALU enabled) -> RESP.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [CMD_W*NUM_REQ-1:0] i_req_cmd,
  input  logic [OPD_W*NUM_REQ-1:0] i_req_a,
  input  logic [OPD_W*NUM_REQ-1:0] i_req_b,
  output logic [CMD_W-1:0]         o_alu_cmd,
  output logic [OPD_W-1:0]         o_alu_a,
  output logic [OPD_W-1:0]         o_alu_b,
  output logic                     o_alu_en,
  input  logic [RES_W-1:0]         i_alu_y,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [RES_W-1:0]         o_rsp_y,
  output logic                     o_busy
);

  state_e            r_state;
  state_e            w_next;
  alu_op_t           r_op;
  alu_op_t           w_sel;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_rsp_id;
  logic [RES_W-1:0]  r_rsp_y;
  logic [ID_W-1:0]   w_grant;
  logic              w_any;
  logic              w_fire;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_grant (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  // Operand mux for the granted requester.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ID_W'(i) == w_grant) begin
        w_sel.cmd = i_req_cmd[i*CMD_W +: CMD_W];
        w_sel.a   = i_req_a[i*OPD_W +: OPD_W];
        w_sel.b   = i_req_b[i*OPD_W +: OPD_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and request handshake; ready never depends on rsp_ready.
  always_comb begin
    w_next      = r_state;
    o_req_ready = '0;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && !i_rst) begin
          o_req_ready[w_grant] = 1'b1;
          w_fire               = 1'b1;
          w_next               = EXEC;
        end
      end
      EXEC: w_next = RESP;
      RESP: begin
        if (i_rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand, pointer and response registers; alu_y is sampled only in EXEC.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op     <= '0;
      r_rr_ptr <= '0;
      r_rsp_id <= '0;
      r_rsp_y  <= '0;
    end else begin
      if (w_fire) begin
        r_op     <= w_sel;
        r_rsp_id <= w_grant;
        r_rr_ptr <= ID_W'(wrap_inc(32'(w_grant), NUM_REQ));
      end
      if (r_state == EXEC) begin
        r_rsp_y <= i_alu_y;
      end
    end
  end

  assign o_alu_cmd   = r_op.cmd;
  assign o_alu_a     = r_op.a;
  assign o_alu_b     = r_op.b;
  assign o_alu_en    = (r_state == EXEC);
  assign o_rsp_valid = (r_state == RESP);
  assign o_busy      = (r_state != IDLE);
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_y     = r_rsp_y;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed scoreboard bench for alu_rr_sched with a behavioural tri-state ALU.
module tb_alu_rr_sched;
  import alu_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [7:0]    y;
  } sb_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [4*N-1:0] req_cmd;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [3:0]     alu_cmd;
  logic [3:0]     alu_a;
  logic [3:0]     alu_b;
  logic           alu_en;
  wire  [7:0]     alu_y;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [7:0]     rsp_y;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_hs     = 0;
  int n_rsp    = 0;

  sb_t        sb[$];
  int         exp_grant[$];
  logic [7:0] exp_y [N];

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = {4'h0, a};
    eb = {4'h0, b};
    case (c)
      4'd0:    return ea + eb;
      4'd1:    return ea - eb;
      4'd2:    return ea & eb;
      4'd3:    return ea | eb;
      4'd4:    return ea ^ eb;
      4'd5:    return ~(ea & eb);
      4'd6:    return ~(ea | eb);
      4'd7:    return ~(ea ^ eb);
      4'd8:    return ea << 1;
      4'd9:    return ea >> 1;
      4'd10:   return ea + 8'd1;
      4'd11:   return ea - 8'd1;
      4'd12:   return ea;
      4'd13:   return eb;
      4'd14:   return ~ea;
      default: return ~eb;
    endcase
  endfunction

  assign alu_y = alu_en ? alu_f(alu_cmd, alu_a, alu_b) : 8'bz;

  alu_rr_sched #(
    .NUM_REQ (N),
    .ID_W    (IW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_cmd   (req_cmd),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_alu_cmd   (alu_cmd),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_en    (alu_en),
    .i_alu_y     (alu_y),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_y     (rsp_y),
    .o_busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input alu_cmd_e c, input logic [3:0] a,
                         input logic [3:0] b, input logic [7:0] y);
    req_cmd[4*i +: 4] = c;
    req_a[4*i +: 4]   = a;
    req_b[4*i +: 4]   = b;
    exp_y[i]          = y;
  endtask

  // Settle inputs, then run the per-cycle monitor and scoreboard.
  task automatic look();
    logic [N-1:0] hs;
    int           id;
    sb_t          e;
    #3;
    if (!rst) begin
      hs = req_ready & req_valid;
      if (hs != '0) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        id = 0;
        for (int i = 0; i < int'(N); i++) if (hs[i]) id = i;
        if (exp_grant.size() != 0) chk("grant_order", 32'(id), 32'(exp_grant.pop_front()));
        sb.push_back('{id: IW'(id), y: exp_y[id]});
        n_hs++;
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_y", 32'(rsp_y), 32'(e.y));
        end
        n_rsp++;
      end
      if (!busy) chk("alu_en_idle", 32'(alu_en), 32'd0);
      chk("rsp_y_known", 32'(!$isunknown(rsp_y)), 32'd1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    look();
    tick();
  endtask

  initial begin
    int hs0;
    int rs0;
    rst       = 1'b1;
    req_valid = '1;
    req_cmd   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(N); i++) exp_y[i] = 8'h00;

    // Reset cycle and post-reset values
    look();
    chk("rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst       = 1'b0;
    req_valid = '0;
    look();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'h00);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_alu_ops", 32'({alu_cmd, alu_a, alu_b}), 32'd0);
    chk("rst_alu_en", 32'(alu_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ptr", 32'(dut.r_rr_ptr), 32'd0);
    tick();

    // Single request: requester 2 ADD 9+8
    set_req(2, ALU_ADD, 4'd9, 4'd8, 8'h11);
    exp_grant.push_back(2);
    req_valid = 4'b0100;
    look();
    chk("single_ready_c0", 32'(req_ready), 32'b0100);
    chk("single_en_c0", 32'(alu_en), 32'd0);
    tick();
    req_valid = '0;
    look();
    chk("single_en_c1", 32'(alu_en), 32'd1);
    chk("single_valid_c1", 32'(rsp_valid), 32'd0);
    tick();
    look();
    chk("single_valid_c2", 32'(rsp_valid), 32'd1);
    chk("single_id_c2", 32'(rsp_id), 32'd2);
    chk("single_y_c2", 32'(rsp_y), 32'h11);
    chk("single_en_c2", 32'(alu_en), 32'd0);
    tick();
    look();
    chk("single_idle_c3", 32'(busy), 32'd0);
    tick();

    // No requests: stay idle, pointer unchanged
    repeat (3) step();
    look();
    chk("noreq_busy", 32'(busy), 32'd0);
    chk("noreq_ptr", 32'(dut.r_rr_ptr), 32'd3);
    tick();

    // Pointer wrap: serve 3 alone, then 0 and 3 together
    set_req(3, ALU_NOT_B, 4'd0, 4'd5, 8'hFA);
    exp_grant.push_back(3);
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    step();
    step();
    set_req(0, ALU_AND, 4'hC, 4'hA, 8'h08);
    exp_grant.push_back(0);
    exp_grant.push_back(3);
    req_valid = 4'b1001;
    look();
    chk("wrap_first", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b1000;
    step();
    step();
    look();
    chk("wrap_second", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    repeat (3) step();

    // Fairness: all valid, distinct XORs, order 0,1,2,3,0
    set_req(0, ALU_XOR, 4'd3, 4'hA, 8'h09);
    set_req(1, ALU_XOR, 4'd4, 4'hA, 8'h0E);
    set_req(2, ALU_XOR, 4'd5, 4'hA, 8'h0F);
    set_req(3, ALU_XOR, 4'd6, 4'hA, 8'h0C);
    for (int g = 0; g < 5; g++) exp_grant.push_back(g % 4);
    hs0 = n_hs;
    rs0 = n_rsp;
    req_valid = '1;
    repeat (15) step();
    req_valid = '0;
    chk("fair_grants", 32'(n_hs - hs0), 32'd5);
    chk("fair_rsps", 32'(n_rsp - rs0), 32'd5);
    chk("fair_order_done", 32'(exp_grant.size()), 32'd0);
    step();

    // Back-pressure: SUB 2-3 held in RESP for 5 cycles
    set_req(1, ALU_SUB, 4'd2, 4'd3, 8'hFF);
    exp_grant.push_back(1);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      look();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_y", 32'(rsp_y), 32'hFF);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    look();
    chk("bp_release_idle", 32'(busy), 32'd0);
    chk("bp_release_valid", 32'(rsp_valid), 32'd0);
    tick();

    // Reset during EXEC discards the transaction
    set_req(2, ALU_ADD, 4'hF, 4'hF, 8'h1E);
    exp_grant.push_back(2);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    look();
    chk("mid_exec_en", 32'(alu_en), 32'd1);
    rst = 1'b1;
    tick();
    sb.delete();
    rst = 1'b0;
    look();
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_en", 32'(alu_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ptr", 32'(dut.r_rr_ptr), 32'd0);
    tick();
    repeat (4) step();
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    chk("end_grants_empty", 32'(exp_grant.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_rr_sched.md
# alu_rr_sched

Round-robin scheduler that shares one combinational 4-bit ALU among `NUM_REQ` requesters. Each requester presents a command and two operands over a valid/ready handshake. The scheduler grants one requester and drives the ALU with registered operands for exactly one execute cycle. It then returns the 8-bit result, tagged with the requester index, over a valid/ready response channel. It sits between the requester-side logic and the ALU instance, and it is the only driver of that ALU's inputs and enable.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ID_W`, 2: requester index width, equal to clog2(`NUM_REQ`).
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset is synchronous and active-high.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit high.
- `req_cmd` in 4*`NUM_REQ`: packed 4-bit ALU commands; requester i uses bits [4i+3:4i].
- `req_a` in 4*`NUM_REQ`: packed operand A.
- `req_b` in 4*`NUM_REQ`: packed operand B.
- `alu_cmd` out 4: command to the ALU.
- `alu_a` out 4: operand A to the ALU.
- `alu_b` out 4: operand B to the ALU.
- `alu_en` out 1: ALU output enable.
- `alu_y` in 8: ALU result; high-Z whenever `alu_en`=0.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: downstream accepts the result.
- `rsp_id` out `ID_W`: index of the requester that owns the result.
- `rsp_y` out 8: registered result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - The grant is computed combinationally: the first requester with `req_valid`=1, searching upward from `rr_ptr` with wrap.
  - `req_ready[grant]`=1 only if some `req_valid` is high.
  - On the handshake, capture cmd/a/b into the operand registers and the index into `rsp_id`. Set `rr_ptr` <= grant+1 (mod `NUM_REQ`). Go to EXEC.
- **EXEC**
  - `alu_en`=1; `alu_cmd`/`alu_a`/`alu_b` come from the operand registers.
  - At the clock edge, `rsp_y` <= `alu_y`. Go to RESP.
- **RESP**
  - `rsp_valid`=1.
  - When `rsp_ready`=1 at the edge, go to IDLE.
- Outside EXEC: `alu_en`=0, and `alu_cmd`/`alu_a`/`alu_b` hold their last registered values. `alu_y` is never sampled outside EXEC.
- Width rule: `rsp_y` is the ALU's 8-bit result passed through unmodified. The ALU evaluates in 8-bit context, so SUB underflow and NOT results carry ones in the upper nibble.
- Boundary conditions:
  - No `req_valid`: stay in IDLE; `rr_ptr` is unchanged.
  - All requesters valid: each is served once per `NUM_REQ` grants.
  - `req_valid` dropped before `req_ready`: no transfer and no state change.
  - `rsp_ready` held low: RESP holds indefinitely with `rsp_y`/`rsp_id` stable; all `req_ready`=0.
  - `rst` mid-transaction: the transaction is discarded.
  - Values after `rst`: state IDLE, `rr_ptr`=0, `rsp_valid`=0, `rsp_y`=8'h00, `rsp_id`=0, `alu_cmd`/`alu_a`/`alu_b`=0, `alu_en`=0, `busy`=0, `req_ready`=0 during the reset cycle.

## Timing
- Cycle N: request handshake (IDLE).
- Cycle N+1: EXEC with `alu_en`=1.
- Cycle N+2: `rsp_valid`=1.
- With `rsp_ready` tied high, the next grant occurs in cycle N+3: one transaction per 3 cycles, and a requester's result appears 2 cycles after its handshake.
- `req_ready` depends combinationally on `req_valid` and the state. It has no dependency on `rsp_ready`.
- All other outputs are registered or decoded from the state only.

## Structure
- Shared package `alu_pkg` holds:
  - the 16 ALU command encodings (ADD=0 … NOT_B=15);
  - the state enum {IDLE, EXEC, RESP}.
- The grant logic is one natural sub-module, `rr_grant`: inputs `req` and `ptr`, outputs `grant` index and `any` flag, purely combinational.
- The FSM, operand registers and response registers live in the top module.

## Test plan
- **Single request:** reset; requester 2 issues ADD a=9 b=8 → `req_ready[2]` in cycle 0, `alu_en`=1 only in cycle 1, `rsp_valid` in cycle 2 with `rsp_y`=8'h11, `rsp_id`=2.
- **Fairness:** all 4 requesters hold valid with a distinct XOR each; `rsp_ready`=1 → grant order 0,1,2,3,0 with each result correct, one response every 3 cycles.
- **Back-pressure:** SUB a=2 b=3 with `rsp_ready`=0 for 5 cycles → `rsp_y`=8'hFF, `rsp_id` stable, all `req_ready`=0; release → IDLE the next cycle.
- **Pointer wrap:** only requester 3 is served, then requesters 0 and 3 request together → 0 is granted first.
- **Reset mid-operation:** assert `rst` during EXEC → next cycle is IDLE with `rsp_valid`=0, `alu_en`=0, `rr_ptr`=0; no response is emitted.
- **Enable isolation:** over the idle stretches of every test, check that `alu_en`=0 and that `rsp_y` never takes X or Z values.
